// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program address width, the PC type, and the
// return-address stack operation decode used by pc_call_stack.
package cpu_pkg;

  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] pc_t;

  // Resolved stack operation for one cycle.
  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_REPLACE  = 3'd3,
    OP_BAD_PUSH = 3'd4,
    OP_BAD_POP  = 3'd5
  } stack_op_e;

  // Maps raw push/pop requests plus stack status onto one operation.
  // push&pop on an empty stack degrades to a plain push (nothing to replace).
  function automatic stack_op_e decode_op(input logic push,
                                          input logic pop,
                                          input logic empty,
                                          input logic full);
    stack_op_e op;
    op = OP_HOLD;
    if (push && pop) begin
      op = empty ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_BAD_PUSH : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_BAD_POP : OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_mem.sv
// Return-address storage: DEPTH x ADDR_W register array with one synchronous
// write port and one asynchronous read port. Contents are never reset.
module pc_stack_mem #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0]        rdata
);

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Write port: one entry updated per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so RET sees the top entry in the same cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_call_stack.sv
// Hardware return-address stack feeding the RET leg of the next-PC mux.
// CALL pushes push_addr, RET pops; top_addr is the current top (0 when empty).
// Build option: define PC_STACK_STICKY_ERR_EN to make err a sticky flag held
// until rst; otherwise err is a combinational pulse in the illegal cycle.
module pc_call_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  output logic [ADDR_W-1:0]        top_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_m1;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [PTR_W-1:0]  mem_raddr;
  logic [ADDR_W-1:0] mem_rdata;
  logic              illegal;
  stack_op_e         op;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign count_m1 = count_q - CNT_W'(1);

  // Top entry sits at count-1; the pointer never wraps, so slicing is safe
  // whenever count is non-zero, and the empty case is forced to zero below.
  assign mem_raddr = count_m1[PTR_W-1:0];
  assign top_addr  = empty ? '0 : mem_rdata;

  // Control decode: next count, storage write, and illegal-op detect.
  // rst overrides any request, so it suppresses writes and errors too.
  always_comb begin
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[PTR_W-1:0];
    illegal   = 1'b0;
    op        = decode_op(push, pop, empty, full);
    if (!rst) begin
      unique case (op)
        OP_PUSH: begin
          mem_we    = 1'b1;
          mem_waddr = count_q[PTR_W-1:0];
          count_d   = count_q + CNT_W'(1);
        end
        OP_POP: begin
          count_d = count_m1;
        end
        OP_REPLACE: begin
          mem_we    = 1'b1;
          mem_waddr = count_m1[PTR_W-1:0];
        end
        OP_BAD_PUSH, OP_BAD_POP: begin
          illegal = 1'b1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  pc_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_addr),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

`ifdef PC_STACK_STICKY_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky error: set by any illegal operation, cleared only by rst.
  always_comb begin
    err_d = err_q | illegal;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = illegal;
`endif

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: directed scenarios followed by random
// push/pop/rst traffic, all compared against a queue-based LIFO model.
module tb_pc_call_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              err;

  int tests  = 0;
  int failed = 0;

  // Reference model: the stack contents as a queue, plus the sticky flag.
  int unsigned model_q[$];
  bit          sticky_m = 1'b0;

  pc_call_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic bit model_illegal();
    if (rst) return 1'b0;
    if (push && !pop && model_q.size() == DEPTH) return 1'b1;
    if (pop && !push && model_q.size() == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned model_top();
    if (model_q.size() == 0) return 0;
    return model_q[model_q.size()-1];
  endfunction

  function automatic bit model_err();
`ifdef PC_STACK_STICKY_ERR_EN
    return sticky_m;
`else
    return model_illegal();
`endif
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Compare every output against the model with the currently driven inputs.
  task automatic check_state(input string tag);
    chk({tag, ".count"}, int'(count), model_q.size());
    chk({tag, ".top"},   int'(top_addr), model_top());
    chk({tag, ".empty"}, int'(empty), int'(model_q.size() == 0));
    chk({tag, ".full"},  int'(full), int'(model_q.size() == DEPTH));
    chk({tag, ".err"},   int'(err), int'(model_err()));
  endtask

  // Apply the clock edge to the model using the inputs sampled at that edge.
  task automatic model_edge();
    if (rst) begin
      model_q.delete();
      sticky_m = 1'b0;
    end else if (push && pop) begin
      if (model_q.size() == 0) model_q.push_back(push_addr);
      else model_q[model_q.size()-1] = push_addr;
    end else if (push) begin
      if (model_q.size() < DEPTH) model_q.push_back(push_addr);
      else sticky_m = 1'b1;
    end else if (pop) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else sticky_m = 1'b1;
    end
  endtask

  // One cycle: drive after negedge, check pre-edge outputs, clock the model.
  task automatic op(input bit r, input bit p, input bit o, input int unsigned a,
                    input string tag, input bit verbose);
    @(negedge clk);
    rst       = r;
    push      = p;
    pop       = o;
    push_addr = ADDR_W'(a);
    #1;
    check_state(tag);
    @(posedge clk);
    model_edge();
    if (verbose)
      $display("[TB] %s rst=%0d push=%0d pop=%0d addr=0x%03h -> model count=%0d top=0x%03h",
               tag, r, p, o, a, model_q.size(), model_top());
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0;
    @(posedge clk);
    model_edge();
    op(1, 0, 0, 0, "reset", 1);
    op(0, 0, 0, 0, "idle", 1);
    chk("reset.count_const", int'(count), 0);
    chk("reset.top_const", int'(top_addr), 0);

    // Three CALLs then a RET.
    op(0, 1, 0, 'h010, "push10", 1);
    op(0, 1, 0, 'h020, "push20", 1);
    op(0, 1, 0, 'h030, "push30", 1);
    op(0, 0, 1, 0, "pop", 1);
    op(0, 0, 0, 0, "after_pop", 1);
    chk("pop.top_const", int'(top_addr), 'h020);
    chk("pop.count_const", int'(count), 2);

    // Fill from empty, then overflow attempt.
    op(1, 0, 0, 0, "rst2", 1);
    for (int i = 0; i < DEPTH; i++) op(0, 1, 0, 'h100 + i, "fill", 1);
    op(0, 1, 0, 'hFFF, "overflow", 1);
    op(0, 0, 0, 0, "after_ovf", 1);
    chk("ovf.top_const", int'(top_addr), 'h107);
    chk("ovf.full_const", int'(full), 1);

    // Drain, then underflow attempt.
    for (int i = 0; i < DEPTH; i++) op(0, 0, 1, 0, "drain", 0);
    op(0, 0, 1, 0, "underflow", 1);
    op(0, 0, 0, 0, "after_unf", 1);
    op(0, 0, 0, 0, "after_unf2", 1);
    chk("unf.count_const", int'(count), 0);

    // Replace on non-empty, then push+pop on empty.
    op(1, 0, 0, 0, "rst3", 1);
    op(0, 1, 0, 'h050, "push50", 1);
    op(0, 1, 1, 'h0AA, "replace", 1);
    op(0, 0, 0, 0, "after_rep", 1);
    chk("rep.top_const", int'(top_addr), 'h0AA);
    op(0, 0, 1, 0, "pop_rep", 1);
    op(0, 1, 1, 'h0BB, "pushpop_empty", 1);
    op(0, 0, 0, 0, "after_ppe", 1);
    chk("ppe.count_const", int'(count), 1);
    chk("ppe.top_const", int'(top_addr), 'h0BB);

    // rst wins over push at count=3.
    op(0, 1, 0, 'h111, "p1", 0);
    op(0, 1, 0, 'h222, "p2", 0);
    op(1, 1, 0, 'h333, "rst_push", 1);
    op(0, 0, 0, 0, "after_rst_push", 1);
    chk("rstpush.empty_const", int'(empty), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      bit r, p, o;
      sel = $urandom_range(0, 99);
      r = (sel < 3);
      p = (sel >= 3 && sel < 48) || (sel >= 83 && sel < 93);
      o = (sel >= 48 && sel < 93);
      op(r, p, o, $urandom_range(0, 4095), "rand", 0);
    end
    op(0, 0, 0, 0, "final", 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
